pc_sequencer: RTL and testbench

Control-flow sequencer that drives the program counter's jump interface (`reljump_en`, `absjump_en`, `target`) from decoded instruction fields. It holds the PC while idle, halted, faulted or stalled by a busy unit. It resolves conditional relative branches, absolute jumps, and call/return through a small return-address stack (RAS). It sits between the instruction decoder and the PC register, one per core.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Control-flow sequencer driving the PC jump interface (hold/branch/jump/call/return).
// Define PC_SEQUENCER_RAS_EN to build the return-address stack and call/ret support.
module pc_sequencer #(
   parameter int width     = 12,
   parameter int RAS_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             busy,
   input  logic                             halt,
   input  logic                             br_rel,
   input  logic                             br_cond,
   input  logic                             jmp_abs,
   input  logic                             call,
   input  logic                             ret,
   input  logic [width-1:0]                 offset,
   input  logic [width-1:0]                 prog_ctr,
   output logic                             reljump_en,
   output logic                             absjump_en,
   output logic [width-1:0]                 target,
   output logic                             done,
   output logic                             fault,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);
   localparam int CW = $clog2(RAS_DEPTH+1);

   typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
   state_t state, state_nxt;

`ifdef PC_SEQUENCER_RAS_EN
   localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   logic [width-1:0] ras_mem [0:(1<<AW)-1];
   logic [CW-1:0]    count;
   logic             push, pop, ras_empty, ras_full;
   logic [width-1:0] ras_top;

   assign ras_empty = (count == '0);
   assign ras_full  = (count == CW'(RAS_DEPTH));
   // Top read index wraps when empty; that path always faults so the value is never used.
   assign ras_top   = ras_mem[AW'(count - 1'b1)];
   assign ras_count = count;

   always_ff @(posedge clk) begin
      if (push) ras_mem[AW'(count)] <= prog_ctr + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    count <= '0;
      else if (push) count <= count + 1'b1;
      else if (pop)  count <= count - 1'b1;
   end
`else
   logic unused_pc;
   assign unused_pc = ^prog_ctr;
   assign ras_count = '0;
`endif

   always_comb begin
      reljump_en = 1'b1;
      absjump_en = 1'b0;
      target     = '0;
      state_nxt  = state;
`ifdef PC_SEQUENCER_RAS_EN
      push       = 1'b0;
      pop        = 1'b0;
`endif
      case (state)
         IDLE, HALT: if (start) state_nxt = RUN;
         RUN: begin
            if (busy) begin
               state_nxt = RUN;
            end else if (halt) begin
               state_nxt = HALT;
            end else if (ret) begin
`ifdef PC_SEQUENCER_RAS_EN
               if (ras_empty) begin
                  state_nxt = FAULT;
               end else begin
                  pop        = 1'b1;
                  reljump_en = 1'b0;
                  absjump_en = 1'b1;
                  target     = ras_top;
               end
`else
               state_nxt = FAULT;
`endif
`ifdef PC_SEQUENCER_RAS_EN
            end else if (call) begin
               if (ras_full) begin
                  state_nxt = FAULT;
               end else begin
                  push       = 1'b1;
                  reljump_en = 1'b0;
                  absjump_en = 1'b1;
                  target     = offset;
               end
            end else if (jmp_abs) begin
`else
            end else if (call || jmp_abs) begin
`endif
               reljump_en = 1'b0;
               absjump_en = 1'b1;
               target     = offset;
            end else if (br_rel && br_cond) begin
               target     = offset;
            end else begin
               reljump_en = 1'b0;
            end
         end
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         done  <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state_nxt == HALT);
         fault <= (state_nxt == FAULT);
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: PC register model, per-cycle reference model compare, directed vectors.
module tb_pc_sequencer;
   localparam int W  = 12;
   localparam int RD = 4;
   localparam int CW = $clog2(RD+1);
`ifdef PC_SEQUENCER_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif
   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

   logic clk = 1'b0;
   logic reset, start, busy, halt, br_rel, br_cond, jmp_abs, call, ret;
   logic [W-1:0] offset, prog_ctr, target;
   logic reljump_en, absjump_en, done, fault;
   logic [CW-1:0] ras_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.width(W), .RAS_DEPTH(RD)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .halt(halt),
      .br_rel(br_rel), .br_cond(br_cond), .jmp_abs(jmp_abs), .call(call), .ret(ret),
      .offset(offset), .prog_ctr(prog_ctr), .reljump_en(reljump_en), .absjump_en(absjump_en),
      .target(target), .done(done), .fault(fault), .ras_count(ras_count)
   );

   // PC register that consumes the jump interface
   always @(posedge clk or negedge reset) begin
      if (!reset)          prog_ctr <= '0;
      else if (absjump_en) prog_ctr <= target;
      else if (reljump_en) prog_ctr <= prog_ctr + target;
      else                 prog_ctr <= prog_ctr + 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sequencer rules applied to a queue-based stack and an expected PC
   int           ms = S_IDLE;
   logic [W-1:0] mpc = '0;
   logic [W-1:0] stk[$];

   always @(negedge clk) begin
      int           nxt_s, cnt;
      logic         e_rel, e_abs;
      logic [W-1:0] e_tgt, nxt_pc;
      #4;
      if (!reset) begin
         ms = S_IDLE; mpc = '0; stk.delete();
      end
      cnt = stk.size();
      e_rel = 1'b1; e_abs = 1'b0; e_tgt = '0; nxt_s = ms; nxt_pc = mpc;
      if ((ms == S_IDLE || ms == S_HALT) && start) begin
         nxt_s = S_RUN;
      end else if (ms == S_RUN && !busy) begin
         if (halt) nxt_s = S_HALT;
         else if (ret) begin
            if (!RAS_EN || stk.size() == 0) nxt_s = S_FAULT;
            else begin
               e_rel = 1'b0; e_abs = 1'b1; e_tgt = stk.pop_back(); nxt_pc = e_tgt;
            end
         end else if (call && RAS_EN) begin
            if (stk.size() == RD) nxt_s = S_FAULT;
            else begin
               stk.push_back(mpc + 12'd1);
               e_rel = 1'b0; e_abs = 1'b1; e_tgt = offset; nxt_pc = offset;
            end
         end else if (call || jmp_abs) begin
            e_rel = 1'b0; e_abs = 1'b1; e_tgt = offset; nxt_pc = offset;
         end else if (br_rel && br_cond) begin
            e_tgt = offset; nxt_pc = mpc + offset;
         end else begin
            e_rel = 1'b0; nxt_pc = mpc + 12'd1;
         end
      end
      chk("prog_ctr",   32'(prog_ctr),   32'(mpc));
      chk("reljump_en", 32'(reljump_en), 32'(e_rel));
      chk("absjump_en", 32'(absjump_en), 32'(e_abs));
      chk("target",     32'(target),     32'(e_tgt));
      chk("done",       32'(done),       32'(ms == S_HALT));
      chk("fault",      32'(fault),      32'(ms == S_FAULT));
      chk("ras_count",  32'(ras_count),  32'(cnt));
      if (reset) begin
         ms = nxt_s; mpc = nxt_pc;
      end
   end

   task automatic next_cycle();
      @(negedge clk);
      start = 0; busy = 0; halt = 0; br_rel = 0; br_cond = 0;
      jmp_abs = 0; call = 0; ret = 0; offset = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      next_cycle(); next_cycle();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic go();
      start = 1'b1;
      next_cycle();
   endtask

   task automatic jump(input logic [W-1:0] a);
      jmp_abs = 1'b1; offset = a;
      next_cycle();
   endtask

   initial begin
      reset = 1'b0;
      start = 0; busy = 0; halt = 0; br_rel = 0; br_cond = 0;
      jmp_abs = 0; call = 0; ret = 0; offset = '0;
      next_cycle();
      #4;
      chk("rst_rel", 32'(reljump_en), 32'd1);
      chk("rst_tgt", 32'(target), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(ras_count), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle(); next_cycle(); next_cycle();
      chk("idle_pc", 32'(prog_ctr), 32'h000);
      go();
      chk("start_pc", 32'(prog_ctr), 32'h000);
      next_cycle();
      chk("inc_pc1", 32'(prog_ctr), 32'h001);
      next_cycle();
      chk("inc_pc2", 32'(prog_ctr), 32'h002);

      // relative branch, taken and untaken
      jump(12'h005);
      br_rel = 1; br_cond = 1; offset = 12'hFFD;
      next_cycle();
      chk("br_taken", 32'(prog_ctr), 32'h002);
      jump(12'h005);
      br_rel = 1; br_cond = 0; offset = 12'hFFD;
      next_cycle();
      chk("br_untaken", 32'(prog_ctr), 32'h006);

      // call / return
      jump(12'h010);
      call = 1; offset = 12'h100;
      next_cycle();
      chk("call_pc", 32'(prog_ctr), 32'h100);
      chk("call_cnt", 32'(ras_count), RAS_EN ? 32'd1 : 32'd0);
      repeat (5) next_cycle();
      chk("pre_ret_pc", 32'(prog_ctr), 32'h105);
      ret = 1;
      next_cycle();
      chk("ret_pc", 32'(prog_ctr), RAS_EN ? 32'h011 : 32'h105);
      chk("ret_fault", 32'(fault), RAS_EN ? 32'd0 : 32'd1);
      chk("ret_cnt", 32'(ras_count), 32'd0);

      // overflow
      do_reset();
      go();
      for (int i = 0; i < 5; i++) begin
         call = 1; offset = 12'h200 + 12'(i * 16);
         next_cycle();
      end
      chk("ovf_fault", 32'(fault), RAS_EN ? 32'd1 : 32'd0);
      chk("ovf_pc", 32'(prog_ctr), RAS_EN ? 32'h230 : 32'h240);
      chk("ovf_cnt", 32'(ras_count), RAS_EN ? 32'd4 : 32'd0);
      next_cycle();
      chk("ovf_hold", 32'(prog_ctr), RAS_EN ? 32'h230 : 32'h241);

      // underflow
      do_reset();
      chk("rst_cnt2", 32'(ras_count), 32'd0);
      go();
      ret = 1;
      next_cycle();
      chk("udf_fault", 32'(fault), 32'd1);
      chk("udf_pc", 32'(prog_ctr), 32'h000);

      // stall with call and jump pending
      do_reset();
      go();
      jump(12'h040);
      for (int i = 0; i < 2; i++) begin
         busy = 1; call = 1; jmp_abs = 1; offset = 12'h300;
         next_cycle();
         chk("busy_hold", 32'(prog_ctr), 32'h040);
      end
      call = 1; jmp_abs = 1; offset = 12'h300;
      next_cycle();
      chk("prio_pc", 32'(prog_ctr), 32'h300);
      chk("prio_cnt", 32'(ras_count), RAS_EN ? 32'd1 : 32'd0);

      // halt / restart
      jump(12'h020);
      halt = 1;
      next_cycle();
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_pc", 32'(prog_ctr), 32'h020);
      next_cycle();
      chk("halt_pc2", 32'(prog_ctr), 32'h020);
      go();
      chk("resume_done", 32'(done), 32'd0);
      chk("resume_pc0", 32'(prog_ctr), 32'h020);
      next_cycle();
      chk("resume_pc1", 32'(prog_ctr), 32'h021);

      next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
